// File: rtl/mesh_pkg.sv
// rtl/mesh_pkg.sv - shared types and helpers for the mesh result drain
// Purpose: drain FSM state encoding and the signed saturation helper.
// Ports: none (package).
package mesh_pkg;

   typedef enum logic [0:0] {
      IDLE = 1'b0,
      SEND = 1'b1
   } drain_state_t;

   // Saturate a sign-extended value to a signed dw-bit range; the result
   // is returned in the low dw bits of a 32-bit word.
   function automatic logic [31:0] sat_to_dw(input logic signed [63:0] v, input int dw);
      logic signed [63:0] hi;
      logic signed [63:0] lo;
      hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
      lo = -hi - 64'sd1;
      if (v > hi)
         return hi[31:0];
      else if (v < lo)
         return lo[31:0];
      else
         return v[31:0];
   endfunction

endpackage

// File: rtl/result_fifo.sv
// rtl/result_fifo.sv - result-vector FIFO for the mesh drain
// Purpose: DEPTH-entry storage of whole result vectors, with the head and
//          the entry behind it visible combinationally.
// Ports: clk, rst (sync, active-high), clr (flush), wr_en/wr_data (push),
//        rd_en (pop head), head, next_head, count, full, empty.
module result_fifo #(
   parameter int DEPTH = 4,
   parameter int W     = 32,
   parameter int CNT_W = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             wr_en,
   input  logic [W-1:0]     wr_data,
   input  logic             rd_en,
   output logic [W-1:0]     head,
   output logic [W-1:0]     next_head,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   localparam int AW = $clog2(DEPTH);

   logic [W-1:0]  mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + AW'(1);
         if (rd_en)
            rd_ptr <= rd_ptr + AW'(1);
         case ({wr_en, rd_en})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en && !rst && !clr)
         mem[wr_ptr] <= wr_data;
   end

   assign head      = mem[rd_ptr];
   // Entry behind the head lets the drain start the next vector with no bubble.
   assign next_head = mem[rd_ptr + AW'(1)];
   assign full      = (count == CNT_W'(DEPTH));
   assign empty     = (count == '0);

endmodule

// File: rtl/result_drain.sv
// rtl/result_drain.sv - buffers mesh result vectors and serialises them row by row
// Purpose: capture result vectors on res_valid, queue up to DEPTH of them and
//          stream one row per beat on a valid/ready interface; drops are flagged
//          in a sticky overflow bit because the mesh cannot stall.
// Config macro: RESULT_DRAIN_SAT_EN (out_data saturated to signed DW bits).
// Ports: clk, rst (sync, active-high), clr (flush), res_valid, result_flat,
//        out_valid, out_ready, out_data, out_row, out_last, fifo_count, overflow.
module result_drain
   import mesh_pkg::*;
#(
   parameter int DW    = 8,
   parameter int ROWS  = 2,
   parameter int ROW_W = 1,
   parameter int DEPTH = 4,
   parameter int CNT_W = 3
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 clr,
   input  logic                 res_valid,
   input  logic [ROWS*2*DW-1:0] result_flat,
   output logic                 out_valid,
   input  logic                 out_ready,
`ifdef RESULT_DRAIN_SAT_EN
   output logic [DW-1:0]        out_data,
`else
   output logic [2*DW-1:0]      out_data,
`endif
   output logic [ROW_W-1:0]     out_row,
   output logic                 out_last,
   output logic [CNT_W-1:0]     fifo_count,
   output logic                 overflow
);

   localparam int RW = 2 * DW;
   localparam int VW = ROWS * RW;
`ifdef RESULT_DRAIN_SAT_EN
   localparam int OW = DW;
`else
   localparam int OW = RW;
`endif

   drain_state_t   state;
   logic [VW-1:0]  head;
   logic [VW-1:0]  next_head;
   logic           full;
   logic           empty;
   logic           accept;
   logic           pop;
   logic           push;

   assign accept = out_valid && out_ready;
   assign pop    = accept && out_last;
   // A pop in the same cycle frees a slot, so a full FIFO can still accept.
   assign push   = res_valid && !rst && !clr && (!full || pop);

   result_fifo #(
      .DEPTH (DEPTH),
      .W     (VW),
      .CNT_W (CNT_W)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .wr_en     (push),
      .wr_data   (result_flat),
      .rd_en     (pop),
      .head      (head),
      .next_head (next_head),
      .count     (fifo_count),
      .full      (full),
      .empty     (empty)
   );

   // Row extraction plus optional saturation, applied as the FIFO is read.
   function automatic logic [OW-1:0] fmt_row(input logic [VW-1:0] vec, input logic [ROW_W-1:0] r);
      logic [RW-1:0] raw;
`ifdef RESULT_DRAIN_SAT_EN
      logic [31:0]   s;
`endif
      raw = vec[r*RW +: RW];
`ifdef RESULT_DRAIN_SAT_EN
      s = sat_to_dw(64'(signed'(raw)), DW);
      return s[OW-1:0];
`else
      return raw;
`endif
   endfunction

   localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         state     <= IDLE;
         out_valid <= 1'b0;
         out_data  <= '0;
         out_row   <= '0;
         out_last  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!empty) begin
                  state     <= SEND;
                  out_valid <= 1'b1;
                  out_data  <= fmt_row(head, '0);
                  out_row   <= '0;
                  out_last  <= (LAST_ROW == '0);
               end else if (push) begin
                  // Bypass: the vector is written this edge, so read it from the input.
                  state     <= SEND;
                  out_valid <= 1'b1;
                  out_data  <= fmt_row(result_flat, '0);
                  out_row   <= '0;
                  out_last  <= (LAST_ROW == '0);
               end
            end
            SEND: begin
               if (accept) begin
                  if (!out_last) begin
                     out_data <= fmt_row(head, out_row + ROW_W'(1));
                     out_row  <= out_row + ROW_W'(1);
                     out_last <= ((out_row + ROW_W'(1)) == LAST_ROW);
                  end else if (fifo_count > CNT_W'(1)) begin
                     out_data <= fmt_row(next_head, '0);
                     out_row  <= '0;
                     out_last <= (LAST_ROW == '0);
                  end else if (push) begin
                     out_data <= fmt_row(result_flat, '0);
                     out_row  <= '0;
                     out_last <= (LAST_ROW == '0);
                  end else begin
                     state     <= IDLE;
                     out_valid <= 1'b0;
                     out_data  <= '0;
                     out_row   <= '0;
                     out_last  <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr)
         overflow <= 1'b0;
      else if (res_valid && full && !pop)
         overflow <= 1'b1;
   end

endmodule

// File: tb/tb_result_drain.sv
// tb/tb_result_drain.sv - directed self-checking bench for result_drain
// Purpose: single vector, back-pressure, overflow, full push+pop, mid-vector
//          reset, clr/res_valid collision and (with RESULT_DRAIN_SAT_EN) saturation.
// Ports: none (top-level bench).
module tb_result_drain;

   logic        clk = 1'b0;
   logic        rst;
   logic        clr;
   logic        res_valid;
   logic [31:0] result_flat;
   logic        out_valid;
   logic        out_ready;
`ifdef RESULT_DRAIN_SAT_EN
   logic [7:0]  out_data;
`else
   logic [15:0] out_data;
`endif
   logic [0:0]  out_row;
   logic        out_last;
   logic [2:0]  fifo_count;
   logic        overflow;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   result_drain #(.DW(8), .ROWS(2), .ROW_W(1), .DEPTH(4), .CNT_W(3)) dut (
      .clk         (clk),
      .rst         (rst),
      .clr         (clr),
      .res_valid   (res_valid),
      .result_flat (result_flat),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_data    (out_data),
      .out_row     (out_row),
      .out_last    (out_last),
      .fifo_count  (fifo_count),
      .overflow    (overflow)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] vec(input logic [15:0] r0, input logic [15:0] r1);
      return {r1, r0};
   endfunction

   task automatic push_one(input logic [31:0] v);
      res_valid   = 1'b1;
      result_flat = v;
      tick();
      res_valid   = 1'b0;
   endtask

   logic [15:0] exp_q [$];

   initial begin
      rst = 1'b1; clr = 1'b0; res_valid = 1'b0; result_flat = '0; out_ready = 1'b1;
      tick(); tick();
      check("rst_valid", 32'(out_valid), 0);
      check("rst_data",  32'(out_data), 0);
      check("rst_row",   32'(out_row), 0);
      check("rst_last",  32'(out_last), 0);
      check("rst_count", 32'(fifo_count), 0);
      check("rst_ovf",   32'(overflow), 0);
      rst = 1'b0;
      tick();

`ifndef RESULT_DRAIN_SAT_EN
      // 1: single vector, latency and ordering
      push_one(vec(16'h0123, 16'hFF00));
      check("t1_valid0", 32'(out_valid), 1);
      check("t1_data0",  32'(out_data), 32'h0123);
      check("t1_row0",   32'(out_row), 0);
      check("t1_last0",  32'(out_last), 0);
      tick();
      check("t1_data1",  32'(out_data), 32'hFF00);
      check("t1_row1",   32'(out_row), 1);
      check("t1_last1",  32'(out_last), 1);
      tick();
      check("t1_idle",   32'(out_valid), 0);
      check("t1_count",  32'(fifo_count), 0);

      // 2: back-pressure holds beat 0
      out_ready = 1'b0;
      push_one(vec(16'h0123, 16'hFF00));
      for (int i = 0; i < 5; i++) begin
         check("t2_hold_valid", 32'(out_valid), 1);
         check("t2_hold_data",  32'(out_data), 32'h0123);
         check("t2_hold_count", 32'(fifo_count), 1);
         if (i < 4) tick();
      end
      out_ready = 1'b1;
      tick();
      check("t2_data1",  32'(out_data), 32'hFF00);
      check("t2_count1", 32'(fifo_count), 1);
      tick();
      check("t2_idle",   32'(out_valid), 0);
      check("t2_count0", 32'(fifo_count), 0);

      // 3: overflow, only the first four vectors drain
      out_ready = 1'b0;
      for (int k = 0; k < 5; k++)
         push_one(vec(16'h1000 + 16'(k), 16'h2000 + 16'(k)));
      check("t3_count", 32'(fifo_count), 4);
      check("t3_ovf",   32'(overflow), 1);
      exp_q.delete();
      for (int k = 0; k < 4; k++) begin
         exp_q.push_back(16'h1000 + 16'(k));
         exp_q.push_back(16'h2000 + 16'(k));
      end
      out_ready = 1'b1;
      for (int b = 0; b < 8; b++) begin
         check("t3_valid", 32'(out_valid), 1);
         check("t3_data",  32'(out_data), 32'(exp_q[b]));
         check("t3_row",   32'(out_row), 32'(b % 2));
         tick();
      end
      check("t3_idle",  32'(out_valid), 0);
      check("t3_ovf_sticky", 32'(overflow), 1);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("t3_clr_ovf", 32'(overflow), 0);

      // 4: push in the cycle the last beat of a full FIFO is accepted
      out_ready = 1'b0;
      for (int k = 0; k < 4; k++)
         push_one(vec(16'h3000 + 16'(k), 16'h4000 + 16'(k)));
      check("t4_full", 32'(fifo_count), 4);
      out_ready = 1'b1;
      tick();
      check("t4_last", 32'(out_last), 1);
      check("t4_lastdata", 32'(out_data), 32'h4000);
      push_one(vec(16'h3004, 16'h4004));
      check("t4_count", 32'(fifo_count), 4);
      check("t4_ovf",   32'(overflow), 0);
      exp_q.delete();
      for (int k = 1; k < 5; k++) begin
         exp_q.push_back(16'h3000 + 16'(k));
         exp_q.push_back(16'h4000 + 16'(k));
      end
      for (int b = 0; b < 8; b++) begin
         check("t4_data", 32'(out_data), 32'(exp_q[b]));
         tick();
      end
      check("t4_idle",  32'(out_valid), 0);
      check("t4_count0", 32'(fifo_count), 0);

      // 5: reset in the middle of a vector
      push_one(vec(16'h5000, 16'h5001));
      check("t5_beat0", 32'(out_data), 32'h5000);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t5_valid", 32'(out_valid), 0);
      check("t5_data",  32'(out_data), 0);
      check("t5_last",  32'(out_last), 0);
      check("t5_count", 32'(fifo_count), 0);
      push_one(vec(16'h6000, 16'h6001));
      check("t5_new_row",  32'(out_row), 0);
      check("t5_new_data", 32'(out_data), 32'h6000);
      tick();
      check("t5_new_data1", 32'(out_data), 32'h6001);
      tick();

      // clr and res_valid together: nothing stored
      clr = 1'b1;
      push_one(vec(16'h7000, 16'h7001));
      clr = 1'b0;
      check("clr_push_count", 32'(fifo_count), 0);
      check("clr_push_valid", 32'(out_valid), 0);
      check("clr_push_ovf",   32'(overflow), 0);
`else
      // 6: saturation to signed 8 bits
      push_one(vec(16'h0123, 16'hFF00));
      check("t6_pos_sat", 32'(out_data), 32'h7F);
      tick();
      check("t6_neg_sat", 32'(out_data), 32'h80);
      tick();
      push_one(vec(16'h0042, 16'hFFF0));
      check("t6_pass",    32'(out_data), 32'h42);
      tick();
      check("t6_neg_pass", 32'(out_data), 32'hF0);
      tick();
      check("t6_idle", 32'(out_valid), 0);
      check("t6_count", 32'(fifo_count), 0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
